// File: rtl/mask_word_writer.sv
// Packs the per-pixel mask stream into 16-bit words, queues them and writes them to the mask frame store.
// Latency: a word completed at edge N raises wr_req in cycle N+1 when the queue was empty.
// Backpressure: none on the stream; a word completed while the queue is full (no same-cycle pop) is dropped and flagged.
//
// Ports: clk_25/rst_n (async active-low); stream valid/mask/mask_x/mask_y;
//        write port wr_req/wr_addr/wr_data/wr_ack; status frame_done/overflow/seq_err, clr_err.
// Optional: define MASK_COUNT_EN to add the per-frame foreground counter and the fg_count output.
module mask_word_writer #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 15
) (
    input  logic              clk_25,
    input  logic              rst_n,
    input  logic              valid,
    input  logic              mask,
    input  logic [9:0]        mask_x,
    input  logic [9:0]        mask_y,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    input  logic              wr_ack,
    output logic              frame_done,
    output logic              overflow,
    output logic              seq_err,
    input  logic              clr_err
`ifdef MASK_COUNT_EN
    ,
    output logic [18:0]       fg_count
`endif
);

    localparam int                WORDS_PER_LINE = H_ACTIVE / 16;
    localparam logic [ADDR_W-1:0] LAST_ADDR      = ADDR_W'(V_ACTIVE * WORDS_PER_LINE - 1);
    localparam int                PTR_W          = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]    DEPTH_CNT      = (PTR_W + 1)'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Packer
    // ------------------------------------------------------------------
    logic [15:0]       pack_word;
    logic [3:0]        exp_idx;
    logic [3:0]        bit_idx;
    logic              idx_err;
    logic              word_done;
    logic [15:0]       merged_word;
    logic [ADDR_W-1:0] sample_addr;

    assign bit_idx   = mask_x[3:0];
    assign idx_err   = valid && (bit_idx != exp_idx);
    assign word_done = valid && (bit_idx == 4'hF);

    // Every sample in a word shares the same address, so the completing
    // sample's coordinates give the word address directly.
    assign sample_addr = ADDR_W'(mask_y) * ADDR_W'(WORDS_PER_LINE) + ADDR_W'(mask_x[9:4]);

    // On an index mismatch the partial word is thrown away and packing
    // restarts from a fresh all-background word at the sample's own bit.
    always_comb begin
        merged_word          = idx_err ? 16'hFFFF : pack_word;
        merged_word[bit_idx] = mask;
    end

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            pack_word <= 16'hFFFF;
            exp_idx   <= 4'd0;
        end else if (valid) begin
            if (word_done) begin
                pack_word <= 16'hFFFF;
                exp_idx   <= 4'd0;
            end else begin
                pack_word <= merged_word;
                exp_idx   <= bit_idx + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Word FIFO
    // ------------------------------------------------------------------
    logic [15:0]       data_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              full;
    logic              pop;
    logic              push;
    logic              drop;

    assign full = (count == DEPTH_CNT);
    assign pop  = wr_req && wr_ack;
    // A same-cycle pop frees the head slot, so a full queue still accepts.
    assign push = word_done && (!full || pop);
    assign drop = word_done && full && !pop;

    assign wr_req  = (count != '0);
    assign wr_addr = addr_mem[rd_ptr];
    assign wr_data = data_mem[rd_ptr];

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the pointers and count define what is live.
    always_ff @(posedge clk_25) begin
        if (push) begin
            data_mem[wr_ptr] <= merged_word;
            addr_mem[wr_ptr] <= sample_addr;
        end
    end

    // ------------------------------------------------------------------
    // Status
    // ------------------------------------------------------------------
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            seq_err    <= 1'b0;
        end else begin
            frame_done <= pop && (wr_addr == LAST_ADDR);
            // A new error in the clearing cycle wins over the clear.
            overflow   <= drop    || (overflow && !clr_err);
            seq_err    <= idx_err || (seq_err  && !clr_err);
        end
    end

`ifdef MASK_COUNT_EN
    // ------------------------------------------------------------------
    // Foreground counter, latched on the frame's last pixel
    // ------------------------------------------------------------------
    logic [18:0] fg_acc;
    logic        fg_inc;
    logic        last_px;

    assign fg_inc  = valid && !mask;
    assign last_px = valid && (mask_x == 10'(H_ACTIVE - 1)) && (mask_y == 10'(V_ACTIVE - 1));

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            fg_acc   <= '0;
            fg_count <= '0;
        end else if (last_px) begin
            fg_count <= fg_acc + 19'(fg_inc);
            fg_acc   <= '0;
        end else if (fg_inc) begin
            fg_acc   <= fg_acc + 19'd1;
        end
    end
`endif

endmodule
